data_memory_arbiter: RTL and testbench

- Two-port arbiter/sequencer in front of the single-ported MIPS data memory.
- Port 0 is the CPU load/store path; port 1 is a secondary master (program/data loader or debug DMA).
- Serialises requests, drives the memory's write_data/address/mem_write/mem_read inputs from registered copies of the winning request, and returns registered read data to the owner.

---
 rtl/data_memory_arbiter.sv | 151 +++++++++++++++
 tb/tb_data_memory_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_arbiter
// Brief   : Two-port request sequencer in front of the single-ported data
//           memory. Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-break.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [DATA_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [DATA_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                state_q;
  logic                  owner_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_write_q;
  logic                  mem_read_q;
  logic                  p0_rvalid_q;
  logic                  p1_rvalid_q;
  logic [DATA_WIDTH-1:0] p0_rdata_q;
  logic [DATA_WIDTH-1:0] p1_rdata_q;
  logic                  gnt0_d;
  logic                  gnt1_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic                  last_grant_q;
`endif

  // Grants are combinational so a requester sees acceptance in its request cycle.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (p0_req_i && p1_req_i) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        gnt0_d = last_grant_q;
        gnt1_d = ~last_grant_q;
`else
        gnt0_d = 1'b1;
`endif
      end else begin
        gnt0_d = p0_req_i;
        gnt1_d = p1_req_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt0_d || gnt1_d) begin
            owner_q     <= gnt1_d;
            we_q        <= gnt1_d ? p1_we_i    : p0_we_i;
            addr_q      <= gnt1_d ? p1_addr_i  : p0_addr_i;
            wdata_q     <= gnt1_d ? p1_wdata_i : p0_wdata_i;
            mem_write_q <= gnt1_d ? p1_we_i    : p0_we_i;
            mem_read_q  <= gnt1_d ? ~p1_we_i   : ~p0_we_i;
            state_q     <= S_ACCESS;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= gnt1_d;
`endif
          end
        end
        S_ACCESS: begin
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          if (we_q) begin
            state_q <= S_IDLE;
          end else begin
            if (owner_q) begin
              p1_rdata_q  <= mem_data_i;
              p1_rvalid_q <= 1'b1;
            end else begin
              p0_rdata_q  <= mem_data_i;
              p0_rvalid_q <= 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          p0_rvalid_q <= 1'b0;
          p1_rvalid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign p0_gnt_o         = gnt0_d;
  assign p1_gnt_o         = gnt1_d;
  assign p0_rvalid_o      = p0_rvalid_q;
  assign p1_rvalid_o      = p1_rvalid_q;
  assign p0_rdata_o       = p0_rdata_q;
  assign p1_rdata_o       = p1_rdata_q;
  assign mem_address_o    = addr_q;
  assign mem_write_data_o = wdata_q;
  assign mem_write_o      = mem_write_q;
  assign mem_read_o       = mem_read_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_memory_arbiter
// Brief   : Directed bench for data_memory_arbiter with a small memory model.
//           Expectations follow DMEM_ARB_ROUND_ROBIN_EN when it is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          p0_req_i = 1'b0, p0_we_i = 1'b0;
  logic [DW-1:0] p0_addr_i = '0, p0_wdata_i = '0;
  logic          p0_gnt_o, p0_rvalid_o;
  logic [DW-1:0] p0_rdata_o;
  logic          p1_req_i = 1'b0, p1_we_i = 1'b0;
  logic [DW-1:0] p1_addr_i = '0, p1_wdata_i = '0;
  logic          p1_gnt_o, p1_rvalid_o;
  logic [DW-1:0] p1_rdata_o;
  logic [DW-1:0] mem_address_o, mem_write_data_o, mem_data_i;
  logic          mem_write_o, mem_read_o, busy_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:15];

  always #5 clk = ~clk;

  // Word-addressed model of the data memory, combinational read.
  assign mem_data_i = mem[mem_address_o[5:2]];
  always @(posedge clk) if (mem_write_o) mem[mem_address_o[5:2]] <= mem_write_data_o;

  data_memory_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_address_o(mem_address_o), .mem_write_data_o(mem_write_data_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .mem_data_i(mem_data_i), .busy_o(busy_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    #1;
    checks++;
    if ({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, mem_write_o, mem_read_o, busy_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, mem_write_o, mem_read_o, busy_o});
    end
    checks++;
    if ({p0_rdata_o, p1_rdata_o, mem_address_o, mem_write_data_o} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want 0", p0_rdata_o, p1_rdata_o,
               mem_address_o, mem_write_data_o);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_write();
    p0_req_i = 1'b1; p0_we_i = 1'b1; p0_addr_i = 32'h1001_0004; p0_wdata_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0) begin
      errors++; $display("FAIL wr_gnt got p0=%b p1=%b want 1 0", p0_gnt_o, p1_gnt_o);
    end
    step();
    p0_req_i = 1'b0; p0_we_i = 1'b0; p0_addr_i = '0; p0_wdata_i = '0;
    #1;
    checks++;
    if (mem_write_o !== 1'b1 || mem_read_o !== 1'b0 || busy_o !== 1'b1 || p0_gnt_o !== 1'b0) begin
      errors++; $display("FAIL wr_access got we=%b re=%b busy=%b gnt=%b want 1 0 1 0",
                         mem_write_o, mem_read_o, busy_o, p0_gnt_o);
    end
    checks++;
    if (mem_address_o !== 32'h1001_0004 || mem_write_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_bus got %h %h want 10010004 deadbeef", mem_address_o, mem_write_data_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || mem_write_o !== 1'b0 || mem[1] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_done got busy=%b we=%b mem=%h want 0 0 deadbeef",
                         busy_o, mem_write_o, mem[1]);
    end
  endtask

  task automatic test_read();
    p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'h1001_0004;
    #1;
    checks++;
    if (p0_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b want 1", p0_gnt_o); end
    step();
    p0_req_i = 1'b0;
    #1;
    checks++;
    if (mem_read_o !== 1'b1 || mem_write_o !== 1'b0 || p0_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL rd_access got re=%b we=%b rv=%b want 1 0 0", mem_read_o, mem_write_o, p0_rvalid_o);
    end
    step();
    checks++;
    if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'hDEAD_BEEF || p1_rvalid_o !== 1'b0 || mem_read_o !== 1'b0) begin
      errors++; $display("FAIL rd_resp got rv0=%b d=%h rv1=%b re=%b want 1 deadbeef 0 0",
                         p0_rvalid_o, p0_rdata_o, p1_rvalid_o, mem_read_o);
    end
    step();
    checks++;
    if (p0_rvalid_o !== 1'b0 || p0_rdata_o !== 32'hDEAD_BEEF || busy_o !== 1'b0) begin
      errors++; $display("FAIL rd_hold got rv=%b d=%h busy=%b want 0 deadbeef 0", p0_rvalid_o, p0_rdata_o, busy_o);
    end
  endtask

  task automatic test_contention();
    logic exp0, exp1;
    mem[4] = 32'hAAAA_0001;
    mem[5] = 32'hBBBB_0002;
    reset = 1'b0;
    step();
    reset = 1'b1;
    p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'h1001_0010;
    p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 32'h1001_0014;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp0 = 1'b0; exp1 = 1'b0;
      if (i % 3 == 0) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp0 = ((i / 3) % 2) == 0;
        exp1 = ((i / 3) % 2) == 1;
`else
        exp0 = 1'b1;
`endif
      end
      checks++;
      if (p0_gnt_o !== exp0 || p1_gnt_o !== exp1) begin
        errors++; $display("FAIL tie_gnt cycle %0d got p0=%b p1=%b want %b %b",
                           i, p0_gnt_o, p1_gnt_o, exp0, exp1);
      end
      step();
    end
    p0_req_i = 1'b0;
    #1;
    checks++;
    if (p1_gnt_o !== 1'b1 || p0_gnt_o !== 1'b0) begin
      errors++; $display("FAIL tie_release got p0=%b p1=%b want 0 1", p0_gnt_o, p1_gnt_o);
    end
    checks++;
    if (p0_rdata_o !== 32'hAAAA_0001) begin
      errors++; $display("FAIL tie_p0_data got %h want aaaa0001", p0_rdata_o);
    end
    step();
    p1_req_i = 1'b0;
    step();
    checks++;
    if (p1_rvalid_o !== 1'b1 || p1_rdata_o !== 32'hBBBB_0002 || p0_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL tie_p1_resp got rv1=%b d=%h rv0=%b want 1 bbbb0002 0",
                         p1_rvalid_o, p1_rdata_o, p0_rvalid_o);
    end
    step();
  endtask

  task automatic test_reset_mid_write();
    mem[2] = 32'h0;
    p1_req_i = 1'b1; p1_we_i = 1'b1; p1_addr_i = 32'h1001_0008; p1_wdata_i = 32'h1234_5678;
    #1;
    checks++;
    if (p1_gnt_o !== 1'b1) begin errors++; $display("FAIL rst_wr_gnt got %b want 1", p1_gnt_o); end
    step();
    p1_req_i = 1'b0; p1_we_i = 1'b0;
    #1;
    checks++;
    if (mem_write_o !== 1'b1) begin errors++; $display("FAIL rst_wr_access got %b want 1", mem_write_o); end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_write_o, mem_read_o, busy_o, p0_rvalid_o, p1_rvalid_o} !== 5'b0 ||
        {mem_address_o, mem_write_data_o, p0_rdata_o, p1_rdata_o} !== 128'h0) begin
      errors++; $display("FAIL rst_abort got ctl=%b addr=%h wd=%h d0=%h d1=%h want 0",
                         {mem_write_o, mem_read_o, busy_o, p0_rvalid_o, p1_rvalid_o},
                         mem_address_o, mem_write_data_o, p0_rdata_o, p1_rdata_o);
    end
    step();
    reset = 1'b1;
    p1_req_i = 1'b1; p1_addr_i = 32'h1001_0008;
    step();
    p1_req_i = 1'b0;
    step();
    checks++;
    if (p1_rvalid_o !== 1'b1 || p1_rdata_o !== 32'h0) begin
      errors++; $display("FAIL rst_readback got rv=%b d=%h want 1 00000000", p1_rvalid_o, p1_rdata_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    mem[6] = 32'hCAFE_F00D;
    p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 32'h1001_0018;
    #1;
    checks++;
    if (p1_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_p1_gnt got %b want 1", p1_gnt_o); end
    step();
    p1_req_i = 1'b0;
    p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'h1001_0004;
    #1;
    checks++;
    if (p0_gnt_o !== 1'b0) begin errors++; $display("FAIL b2b_gnt_access got %b want 0", p0_gnt_o); end
    step();
    checks++;
    if (p0_gnt_o !== 1'b0 || p1_rvalid_o !== 1'b1 || p1_rdata_o !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_resp got g0=%b rv1=%b d1=%h want 0 1 cafef00d",
                         p0_gnt_o, p1_rvalid_o, p1_rdata_o);
    end
    step();
    checks++;
    if (p0_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt_idle got %b want 1", p0_gnt_o); end
    step();
    p0_req_i = 1'b0;
    step();
    checks++;
    if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'hDEAD_BEEF || p1_rvalid_o !== 1'b0 ||
        p1_rdata_o !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_hold got rv0=%b d0=%h rv1=%b d1=%h want 1 deadbeef 0 cafef00d",
                         p0_rvalid_o, p0_rdata_o, p1_rvalid_o, p1_rdata_o);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
